// File: rtl/uart_arb_pkg.sv
// Shared constants, state encoding and index-width helper for the uart_tx arbiter.
package uart_arb_pkg;
  localparam int ARB_NUM_REQ_DEF = 3;
  localparam int ARB_BYTE_W      = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_e;

  function automatic int arb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_arb_pick.sv
// Combinational winner search: first set bit of req_i at or after start_i, wrapping.
// Fixed priority is simply start_i = 0.
module uart_arb_pick
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = ARB_NUM_REQ_DEF,
  localparam int IW      = arb_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      start_i,
  output logic [IW-1:0]      idx_o,
  output logic               found_o
);
  // Scan from farthest to nearest so the nearest hit is the final write.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(start_i) + k) % NUM_REQ]) begin
        idx_o   = IW'((int'(start_i) + k) % NUM_REQ);
        found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the shared uart_tx byte port to one requester per framed message.
// Define UART_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ        = ARB_NUM_REQ_DEF,
  parameter  int TIMEOUT_CYCLES = 27_000_000,
  localparam int IW             = arb_idx_w(NUM_REQ)
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ARB_BYTE_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ARB_BYTE_W-1:0]          tx_data,
  output logic                           tx_data_valid,
  input  logic                           tx_data_ready,
  output logic [IW-1:0]                  grant_id,
  output logic                           busy,
  output logic                           timeout_pulse
);
  localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYCLES);
`ifdef UART_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d, last_grant_q, last_grant_d;
  logic [ARB_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  hold_last_q, hold_last_d;
  logic [SW-1:0]         stall_q, stall_d;
  logic                  tout_q, tout_d;

  logic [IW-1:0] rr_start, start, pick_idx;
  logic          found, gvalid, tx_hs;

  assign rr_start = (last_grant_q == IW'(NUM_REQ - 1)) ? '0 : last_grant_q + 1'b1;
  assign start    = RR_EN ? rr_start : '0;

  uart_arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req_valid),
    .start_i (start),
    .idx_o   (pick_idx),
    .found_o (found)
  );

  assign gvalid = req_valid[grant_q];
  assign tx_hs  = tx_valid_q & tx_data_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      hold_last_q  <= 1'b0;
      stall_q      <= '0;
      tout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      hold_last_q  <= hold_last_d;
      stall_q      <= stall_d;
      tout_q       <= tout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    hold_last_d  = hold_last_q;
    stall_d      = stall_q;
    tout_d       = 1'b0;
    req_ready    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d      = ARB_XFER;
          grant_d      = pick_idx;
          last_grant_d = pick_idx;
          stall_d      = '0;
        end
      end
      ARB_XFER: begin
        // One-byte holding register: loads and uart_tx handshakes never share a cycle.
        req_ready[grant_q] = ~tx_valid_q;
        if (gvalid && !tx_valid_q) begin
          tx_data_d   = req_data[grant_q*ARB_BYTE_W +: ARB_BYTE_W];
          tx_valid_d  = 1'b1;
          hold_last_d = req_last[grant_q];
          stall_d     = '0;
        end else if (tx_hs) begin
          tx_valid_d = 1'b0;
          if (hold_last_q) state_d = ARB_IDLE;
        end else if (!tx_valid_q) begin
          if ((TIMEOUT_CYCLES != 0) && (stall_q == STALL_MAX)) begin
            state_d = ARB_IDLE;
            tout_d  = 1'b1;
          end else if (stall_q != STALL_MAX) begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q == ARB_XFER);
  assign timeout_pulse = tout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: per-cycle vector table, directed corner sequences and
// randomized multi-source traffic against a message-level scoreboard.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;
  localparam int N  = 3;
  localparam int TO = 10;
`ifdef UART_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic           sys_clk = 1'b0, sys_rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [N*8-1:0] req_data = '0;
  logic [7:0]     tx_data;
  logic           tx_data_valid, tx_data_ready = 1'b0;
  logic [1:0]     grant_id;
  logic           busy, timeout_pulse;

  int checks = 0, failures = 0;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_data_ready(tx_data_ready),
    .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- environment: source queues, uart_tx sink, scoreboard
  bit         auto_en = 1'b0, sb_en = 1'b0;
  int         tx_mode = 0;               // 0: ready high, 1: random, 2: held low
  logic [8:0] srcq [N][$];               // {last, byte} still to be offered
  logic [8:0] expq [N][$];               // {last, byte} still expected at uart_tx
  longint     since [N];
  longint     cyc = 0, end_cyc = 0;
  int         cur_src = -1, prev_src = -1;
  bit         have_prev = 1'b0;
  int         order_q[$];
  logic [7:0] out_q[$];
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;
  int         tout_cnt = 0;

  // Rank of requester x in the search order following the previous grantee p.
  function automatic int rank(input int x, input int p);
    int base;
    base = RR ? p + 1 : 0;
    return (x - base + 2 * N) % N;
  endfunction

  task automatic sb_byte(input logic [7:0] d);
    int s;
    logic [8:0] e;
    bit bad;
    if (cur_src < 0) begin
      s = int'(d[7:5]);
      if (s >= N || expq[s].size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_start byte=%0h has no pending message", d);
        return;
      end
      if (have_prev) begin
        bad = 1'b0;
        for (int j = 0; j < N; j++)
          if (j != s && req_valid[j] && since[j] <= end_cyc && rank(j, prev_src) < rank(s, prev_src))
            bad = 1'b1;
        chk("sb_priority", {31'b0, bad}, 32'd0);
      end
      order_q.push_back(s);
      cur_src = s;
    end
    if (expq[cur_src].size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_extra byte=%0h src=%0d", d, cur_src);
      return;
    end
    e = expq[cur_src].pop_front();
    chk("sb_byte", {24'b0, d}, {24'b0, e[7:0]});
    if (e[8]) begin
      prev_src  = cur_src;
      cur_src   = -1;
      have_prev = 1'b1;
      end_cyc   = cyc;
    end
  endtask

  always @(negedge sys_clk) begin
    cyc++;
    if (auto_en) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() > 0) begin
          if (!req_valid[i]) since[i] = cyc;
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = srcq[i][0][7:0];
          req_last[i]        = srcq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
          req_last[i]  = 1'b0;
        end
        if (req_valid[i] && req_ready[i]) void'(srcq[i].pop_front());
      end
      case (tx_mode)
        0:       tx_data_ready = 1'b1;
        1:       tx_data_ready = ($urandom_range(0, 2) != 0);
        default: tx_data_ready = 1'b0;
      endcase
    end
    if (!sys_rst_n) begin
      pv = 1'b0; cur_src = -1; have_prev = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("tx_hold_valid", {31'b0, tx_data_valid}, 32'd1);
        chk("tx_hold_data", {24'b0, tx_data}, {24'b0, pd});
      end
      if (timeout_pulse) begin
        tout_cnt++; cur_src = -1; have_prev = 1'b0;
      end
      if (tx_data_valid && tx_data_ready) begin
        out_q.push_back(tx_data);
        if (sb_en) sb_byte(tx_data);
      end
      pv = tx_data_valid; pr = tx_data_ready; pd = tx_data;
    end
  end

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete(); expq[i].delete();
    end
    out_q.delete(); order_q.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic push_msg(input int s, input int m, input int len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = {3'(s), 2'(m), 3'(k)};
      srcq[s].push_back({k == len - 1, b});
      expq[s].push_back({k == len - 1, b});
    end
  endtask

  function automatic bit all_done();
    for (int i = 0; i < N; i++) if (expq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- vector table: requester 1 sends "AB\r\n", uart_tx always ready
  typedef struct packed {
    logic       v;  logic [7:0] d;   logic l;
    logic [2:0] rdy; logic txv; logic [7:0] txd; logic bsy; logic [1:0] gnt;
  } vec_t;
  vec_t vt [10];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k, t0, cnt;
    int exp_ord [4];
    vt[0] = '{1'b1, 8'h41, 1'b0, 3'b010, 1'b0, 8'h00, 1'b1, 2'd1};
    vt[1] = '{1'b1, 8'h41, 1'b0, 3'b000, 1'b1, 8'h41, 1'b1, 2'd1};
    vt[2] = '{1'b1, 8'h42, 1'b0, 3'b010, 1'b0, 8'h41, 1'b1, 2'd1};
    vt[3] = '{1'b1, 8'h42, 1'b0, 3'b000, 1'b1, 8'h42, 1'b1, 2'd1};
    vt[4] = '{1'b1, 8'h0D, 1'b0, 3'b010, 1'b0, 8'h42, 1'b1, 2'd1};
    vt[5] = '{1'b1, 8'h0D, 1'b0, 3'b000, 1'b1, 8'h0D, 1'b1, 2'd1};
    vt[6] = '{1'b1, 8'h0A, 1'b1, 3'b010, 1'b0, 8'h0D, 1'b1, 2'd1};
    vt[7] = '{1'b1, 8'h0A, 1'b1, 3'b000, 1'b1, 8'h0A, 1'b1, 2'd1};
    vt[8] = '{1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 8'h0A, 1'b0, 2'd1};
    vt[9] = '{1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 8'h0A, 1'b0, 2'd1};

    // reset values, applied asynchronously before any clock edge matters
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_data_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_grant", {30'b0, grant_id}, 32'd0);
    chk("rst_req_ready", {29'b0, req_ready}, 32'd0);
    chk("rst_timeout", {31'b0, timeout_pulse}, 32'd0);
    tx_data_ready = 1'b1;
    do_reset();

    for (int r = 0; r < 10; r++) begin
      @(negedge sys_clk);
      req_valid = {1'b0, vt[r].v, 1'b0};
      req_data[15:8] = vt[r].d;
      req_last = {1'b0, vt[r].l, 1'b0};
      @(posedge sys_clk); #1;
      chk($sformatf("vec%0d_req_ready", r), {29'b0, req_ready}, {29'b0, vt[r].rdy});
      chk($sformatf("vec%0d_tx_valid", r), {31'b0, tx_data_valid}, {31'b0, vt[r].txv});
      chk($sformatf("vec%0d_tx_data", r), {24'b0, tx_data}, {24'b0, vt[r].txd});
      chk($sformatf("vec%0d_busy", r), {31'b0, busy}, {31'b0, vt[r].bsy});
      chk($sformatf("vec%0d_grant", r), {30'b0, grant_id}, {30'b0, vt[r].gnt});
    end

    // contention: requesters 0 and 2 each queue two 3-byte messages at once
    auto_en = 1'b1; tx_mode = 0;
    do_reset();
    sb_en = 1'b1;
    @(posedge sys_clk);
    push_msg(0, 0, 3); push_msg(0, 1, 3);
    push_msg(2, 0, 3); push_msg(2, 1, 3);
    for (k = 0; k < 200 && !all_done(); k++) @(posedge sys_clk);
    chk("cont_wait", {31'b0, k < 200}, 32'd1);
    if (RR) exp_ord = '{0, 2, 0, 2}; else exp_ord = '{0, 0, 2, 2};
    chk("cont_msgs", order_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      chk($sformatf("cont_order%0d", i), order_q[i], exp_ord[i]);
    sb_en = 1'b0;

    // stall timeout: one byte without last, then requester 1 goes quiet
    do_reset();
    tout_cnt = 0;
    @(posedge sys_clk);
    srcq[1].push_back({1'b0, 8'h55});
    for (k = 0; k < 20 && out_q.size() < 1; k++) @(negedge sys_clk);
    chk("to_byte_wait", {31'b0, k < 20}, 32'd1);
    if (out_q.size() > 0) chk("to_byte", {24'b0, out_q[0]}, 32'h55);
    srcq[0].push_back({1'b1, 8'h30});
    t0 = 0;
    for (cnt = 1; cnt <= 30; cnt++) begin
      @(posedge sys_clk); #1;
      if (timeout_pulse) begin t0 = cnt; break; end
    end
    chk("to_pulse_seen", {31'b0, t0 != 0}, 32'd1);
    chk("to_delay_window", {31'b0, t0 >= TO && t0 <= TO + 2}, 32'd1);
    chk("to_busy_low", {31'b0, busy}, 32'd0);
    @(posedge sys_clk); #1;
    chk("to_pulse_width", {31'b0, timeout_pulse}, 32'd0);
    chk("to_regrant_busy", {31'b0, busy}, 32'd1);
    chk("to_regrant_id", {30'b0, grant_id}, 32'd0);
    for (k = 0; k < 20 && out_q.size() < 2; k++) @(negedge sys_clk);
    chk("to_req0_wait", {31'b0, k < 20}, 32'd1);
    if (out_q.size() > 1) chk("to_req0_byte", {24'b0, out_q[1]}, 32'h30);
    chk("to_count", tout_cnt, 32'd1);

    // back-pressure: uart_tx not ready for 50 cycles
    do_reset();
    tx_mode = 2;
    @(posedge sys_clk);
    srcq[2].push_back({1'b0, 8'hA1}); srcq[2].push_back({1'b1, 8'hA2});
    for (k = 0; k < 20 && !tx_data_valid; k++) begin @(posedge sys_clk); #1; end
    chk("bp_valid_wait", {31'b0, k < 20}, 32'd1);
    t0 = tout_cnt;
    for (int c = 0; c < 50; c++) begin
      @(posedge sys_clk); #1;
      chk("bp_valid", {31'b0, tx_data_valid}, 32'd1);
      chk("bp_data", {24'b0, tx_data}, 32'hA1);
      chk("bp_req_ready", {29'b0, req_ready}, 32'd0);
      chk("bp_timeout", {31'b0, timeout_pulse}, 32'd0);
    end
    tx_mode = 0;
    for (k = 0; k < 20 && out_q.size() < 2; k++) @(negedge sys_clk);
    chk("bp_drain_wait", {31'b0, k < 20}, 32'd1);
    if (out_q.size() > 1) begin
      chk("bp_byte0", {24'b0, out_q[0]}, 32'hA1);
      chk("bp_byte1", {24'b0, out_q[1]}, 32'hA2);
    end
    chk("bp_no_timeout", tout_cnt, t0);

    // reset mid-message after 2 of 5 bytes
    do_reset();
    @(posedge sys_clk);
    for (int i = 0; i < 5; i++) srcq[0].push_back({i == 4, 8'(8'h60 + i)});
    for (k = 0; k < 40 && out_q.size() < 2; k++) @(negedge sys_clk);
    chk("mr_wait", {31'b0, k < 40}, 32'd1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mr_tx_data", {24'b0, tx_data}, 32'h0);
    chk("mr_tx_valid", {31'b0, tx_data_valid}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_grant", {30'b0, grant_id}, 32'd0);
    chk("mr_req_ready", {29'b0, req_ready}, 32'd0);
    srcq[0].delete(); out_q.delete();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    srcq[2].push_back({1'b1, 8'h77});
    for (k = 0; k < 20 && out_q.size() < 1; k++) @(negedge sys_clk);
    chk("mr_regrant_wait", {31'b0, k < 20}, 32'd1);
    if (out_q.size() > 0) chk("mr_regrant_byte", {24'b0, out_q[0]}, 32'h77);
    chk("mr_regrant_id", {30'b0, grant_id}, 32'd2);

    // randomized traffic against the message scoreboard
    do_reset();
    sb_en = 1'b1; tx_mode = 1;
    t0 = tout_cnt;
    for (int m = 0; m < 40; m++) begin
      repeat ($urandom_range(0, 6)) @(posedge sys_clk);
      cnt = $urandom_range(0, N - 1);
      if (srcq[cnt].size() < 8) push_msg(cnt, m % 4, $urandom_range(1, 4));
    end
    for (k = 0; k < 3000 && !all_done(); k++) @(posedge sys_clk);
    chk("rnd_drain_wait", {31'b0, k < 3000}, 32'd1);
    repeat (3) @(posedge sys_clk);
    chk("rnd_no_partial", cur_src, -1);
    chk("rnd_no_timeout", tout_cnt, t0);
    sb_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` byte interface among several independent message sources, such as the echo path, the state-machine printf path and future debug loggers. Each requester streams a framed message (bytes plus a last flag). The arbiter grants one requester at a time and holds the grant until the whole message has been handed to `uart_tx`, so messages never interleave. It sits between the application logic in `top` and `uart_tx_inst`, and it replaces the ad-hoc SEND/WAIT muxing of `tx_data`.

## Interface
- `NUM_REQ`, default 3: number of requesters, range 2..8.
- `TIMEOUT_CYCLES`, default 27_000_000: maximum stall between bytes of a granted message before the grant is revoked (1 s at 27 MHz). 0 disables the timeout.
- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low. Clock is `sys_clk`.
- `req_valid` in NUM_REQ: per-requester byte valid.
- `req_data` in NUM_REQ*8: byte of requester i at `[i*8 +: 8]`.
- `req_last` in NUM_REQ: byte is the final byte of its message.
- `req_ready` out NUM_REQ: byte accepted when `req_valid[i] && req_ready[i]`.
- `tx_data` out 8: to `uart_tx.tx_data`.
- `tx_data_valid` out 1: to `uart_tx.tx_data_valid`.
- `tx_data_ready` in 1: from `uart_tx.tx_data_ready`.
- `grant_id` out $clog2(NUM_REQ): current or most recent grantee.
- `busy` out 1: high in state XFER.
- `timeout_pulse` out 1: one-cycle strobe when a grant is revoked by the timeout.

## Operation
- States: IDLE, XFER.
- IDLE:
  - If any `req_valid` bit is set, pick a winner, register it into `grant_id`, and go to XFER.
  - With no request, stay in IDLE.
- XFER:
  - `req_ready[grant_id] = ~hold_full`. Every other `req_ready` bit is 0.
  - On a handshake: `tx_data <= req_data[grant]`, `tx_data_valid <= 1`, `hold_last <= req_last[grant]`.
  - On `tx_data_valid && tx_data_ready`: `tx_data_valid <= 0`. If `hold_last` is set, go to IDLE.
- `hold_full` is identical to `tx_data_valid`. The holding register is exactly one byte deep.
- Stall counter:
  - Counts in XFER while `~tx_data_valid && ~req_valid[grant]`, saturating at TIMEOUT_CYCLES.
  - Clears on any handshake and on entry to XFER.
  - When it reaches TIMEOUT_CYCLES (nonzero): go to IDLE, pulse `timeout_pulse`, and drop the partial message.
  - The timeout never fires while a byte is held; the held byte is always delivered first.
- Winner selection: see Configuration. The chosen index is also stored as `last_grant`.
- Requests that are not granted are simply back-pressured. Nothing is dropped and nothing is counted.

## Timing
- Reset values:
  - State IDLE.
  - `tx_data = 8'h00`, `tx_data_valid = 0`.
  - `grant_id = 0`, `last_grant = NUM_REQ-1` (so round-robin starts at index 0).
  - `busy = 0`, `timeout_pulse = 0`, `req_ready = 0`, stall counter 0.
- Request to first byte:
  - Cycle 0: `req_valid` seen in IDLE.
  - Cycle 1: XFER and `req_ready` high, first handshake.
  - Cycle 2: `tx_data_valid = 1`.
- Between bytes:
  - After the `uart_tx` handshake, `req_ready` rises the next cycle.
  - A byte cannot be loaded in the same cycle as the `uart_tx` handshake.
- End of message:
  - The last-byte `uart_tx` handshake returns the FSM to IDLE on the next cycle.
  - Re-arbitration takes one cycle, so the minimum gap between messages is 2 cycles of `tx_data_valid` low.
- A single-byte message (`req_last` set on the first byte) is valid.
- `req_valid` that rises or falls in IDLE is sampled only in IDLE. A requester may withdraw before it is granted.
- Reset asserted mid-message: all state clears immediately. `uart_tx` is reset by the same signal, so a partial frame is aborted.
- `tx_data_valid` never deasserts without a `tx_data_ready` handshake, except on reset.

## Configuration
- With `UART_ARB_ROUND_ROBIN_EN` defined:
  - The search starts at `last_grant+1` modulo NUM_REQ.
  - The first requester with `req_valid` set wins.
- Without the macro:
  - Fixed priority: the lowest index with `req_valid` set wins.
  - `last_grant` is still registered but unused.

## Structure
- Package `uart_arb_pkg` holds:
  - State encoding constants `ARB_IDLE` / `ARB_XFER`.
  - Default `NUM_REQ`.
  - Byte width constant 8.
  - The `$clog2`-based index width function.
- Sub-module `uart_arb_pick` is combinational. It takes `req` vector and start index and returns the winner index and a `found` flag.
  - Both the round-robin and fixed-priority variants live in this sub-module.
  - Fixed priority is the same logic with start index 0.

## Test plan
- Single message: requester 1 streams "AB\r\n" (last on 0x0A) with a `uart_tx` model.
  - `tx_data` sequence is 0x41, 0x42, 0x0D, 0x0A.
  - `grant_id = 1` throughout, then `busy` falls.
- Contention, round-robin build: requesters 0 and 2 each hold a 3-byte message from the same cycle. Both enter IDLE again for second messages.
  - Order is 0, 2, 0, 2.
  - No bytes interleave within a message.
- Same contention, fixed-priority build:
  - Requester 0 completes both of its messages before requester 2 gets any grant.
- Stall timeout with TIMEOUT_CYCLES=10: requester 1 sends 1 byte without last, then drops `req_valid`.
  - The byte is delivered.
  - 10 cycles later `timeout_pulse` is high for 1 cycle and the state returns to IDLE.
  - Requester 0 is then granted.
- Back-pressure: hold `tx_data_ready` low 50 cycles with `tx_data_valid` high.
  - `tx_data` is stable and `req_ready` is 0.
  - No timeout pulse.
- Reset mid-message after 2 of 5 bytes:
  - All outputs return to their reset values asynchronously.
  - After release, a new request is granted from IDLE.
